// File: rtl/code_stream_decoder.sv
// Decodes a Gray or one-hot 3-bit code stream, tracks sequence lock, and counts errors.
// Latency: one cycle, all outputs registered. There is no backpressure: a code is accepted on every in_valid cycle.
module code_stream_decoder #(
  parameter int USE_GRAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] code_in,
  input  logic       err_clr,
  output logic       out_valid,
  output logic [2:0] value_out,
  output logic       illegal,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] run, run_nxt;
  logic [2:0] prev, prev_nxt, prev_inc;
  logic       legal;
  logic [2:0] dec_val;
  logic       in_seq;
  logic       ill_nxt, seq_nxt, err_inc;

  generate
    if (USE_GRAY != 0) begin : g_gray
      assign legal      = (code_in[6:3] == 4'd0);
      assign dec_val[2] = code_in[2];
      assign dec_val[1] = code_in[2] ^ code_in[1];
      assign dec_val[0] = code_in[2] ^ code_in[1] ^ code_in[0];
    end else begin : g_onehot
      // At most one bit set; the OR-accumulated index is only meaningful when legal.
      always_comb begin
        legal   = ((code_in & (code_in - 7'd1)) == 7'd0);
        dec_val = 3'd0;
        for (int k = 0; k < 7; k++) begin
          if (code_in[k]) dec_val = dec_val | 3'(k + 1);
        end
      end
    end
  endgenerate

  assign prev_inc = prev + 3'd1;
  assign in_seq   = (dec_val == prev_inc);
  assign err_inc  = ill_nxt | seq_nxt;

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    run_nxt   = run;
    ill_nxt   = 1'b0;
    seq_nxt   = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        ill_nxt   = 1'b1;
        state_nxt = UNLOCKED;
      end else begin
        case (state)
          UNLOCKED: begin
            prev_nxt  = dec_val;
            run_nxt   = 2'd0;
            state_nxt = TRACK;
          end
          TRACK: begin
            prev_nxt = dec_val;
            if (in_seq) begin
              run_nxt = run + 2'd1;
              if (run == 2'd2) state_nxt = LOCKED;
            end else begin
              run_nxt = 2'd0;
            end
          end
          LOCKED: begin
            prev_nxt = dec_val;
            if (!in_seq) begin
              seq_nxt   = 1'b1;
              run_nxt   = 2'd0;
              state_nxt = TRACK;
            end
          end
          default: state_nxt = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      run       <= 2'd0;
      prev      <= 3'd0;
      out_valid <= 1'b0;
      value_out <= 3'd0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      prev      <= prev_nxt;
      out_valid <= in_valid;
      illegal   <= ill_nxt;
      seq_err   <= seq_nxt;
      if (in_valid) value_out <= legal ? dec_val : 3'd0;
      // Clear wins over a same-cycle increment; the count saturates rather than wrapping.
      if (err_clr) err_count <= 8'd0;
      else if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_code_stream_decoder.sv
// Directed bench driving a Gray-mode and a one-hot-mode decoder side by side.
module tb_code_stream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       g_vld, g_clr, o_vld, o_clr;
  logic [6:0] g_code, o_code;
  logic       g_ovld, g_ill, g_seq, g_lck;
  logic       o_ovld, o_ill, o_seq, o_lck;
  logic [2:0] g_val, o_val;
  logic [7:0] g_cnt, o_cnt;

  int errors = 0;
  int checks = 0;

  code_stream_decoder #(.USE_GRAY(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .in_valid(g_vld), .code_in(g_code), .err_clr(g_clr),
    .out_valid(g_ovld), .value_out(g_val), .illegal(g_ill), .seq_err(g_seq),
    .locked(g_lck), .err_count(g_cnt)
  );

  code_stream_decoder #(.USE_GRAY(0)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(o_vld), .code_in(o_code), .err_clr(o_clr),
    .out_valid(o_ovld), .value_out(o_val), .illegal(o_ill), .seq_err(o_seq),
    .locked(o_lck), .err_count(o_cnt)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    g_vld = 1'b0; g_clr = 1'b0; g_code = 7'd0;
    o_vld = 1'b0; o_clr = 1'b0; o_code = 7'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({g_ovld, g_val, g_ill, g_seq, g_lck, g_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_gray: got %b want all zero", {g_ovld, g_val, g_ill, g_seq, g_lck, g_cnt});
    end
    checks++;
    if ({o_ovld, o_val, o_ill, o_seq, o_lck, o_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_onehot: got %b want all zero", {o_ovld, o_val, o_ill, o_seq, o_lck, o_cnt});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_gray_lock;
    logic [6:0] codes [4] = '{7'b0000010, 7'b0000110, 7'b0000111, 7'b0000101};
    logic [2:0] exp   [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 4; i++) begin
      g_vld = 1'b1; g_code = codes[i];
      @(negedge clk);
      checks++;
      if ({g_ovld, g_val, g_ill, g_seq} !== {1'b1, exp[i], 2'b00}) begin
        errors++;
        $display("FAIL gray_lock_out[%0d]: vld/val/ill/seq=%b/%0d/%b/%b want 1/%0d/0/0", i, g_ovld, g_val, g_ill, g_seq, exp[i]);
      end
      checks++;
      if (g_lck !== (i == 3)) begin
        errors++;
        $display("FAIL gray_lock_locked[%0d]: got %b want %b", i, g_lck, (i == 3));
      end
    end
    g_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({g_ovld, g_val, g_lck} !== {1'b0, 3'd6, 1'b1}) begin
      errors++;
      $display("FAIL gray_idle_hold: vld/val/lck=%b/%0d/%b want 0/6/1", g_ovld, g_val, g_lck);
    end
  endtask

  task automatic test_gray_illegal;
    g_vld = 1'b1; g_code = 7'b0001000;
    @(negedge clk);
    g_vld = 1'b0;
    checks++;
    if ({g_ovld, g_ill, g_seq, g_val, g_cnt, g_lck} !== {1'b1, 1'b1, 1'b0, 3'd0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL gray_illegal: vld/ill/seq/val/cnt/lck=%b/%b/%b/%0d/%0d/%b want 1/1/0/0/1/0", g_ovld, g_ill, g_seq, g_val, g_cnt, g_lck);
    end
    @(negedge clk);
    checks++;
    if ({g_ovld, g_ill} !== 2'b00) begin
      errors++;
      $display("FAIL gray_illegal_pulse: vld/ill=%b/%b want 0/0", g_ovld, g_ill);
    end
  endtask

  task automatic test_onehot_seq;
    logic [6:0] codes [4] = '{7'b0100000, 7'b1000000, 7'b0000000, 7'b0000001};
    logic [2:0] exp   [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [6:0] rel   [3] = '{7'b0010000, 7'b0100000, 7'b1000000};
    for (int i = 0; i < 4; i++) begin
      o_vld = 1'b1; o_code = codes[i];
      @(negedge clk);
      checks++;
      if ({o_ovld, o_val, o_ill, o_seq, o_lck} !== {1'b1, exp[i], 2'b00, (i == 3)}) begin
        errors++;
        $display("FAIL onehot_lock[%0d]: vld/val/ill/seq/lck=%b/%0d/%b/%b/%b want 1/%0d/0/0/%b", i, o_ovld, o_val, o_ill, o_seq, o_lck, exp[i], (i == 3));
      end
    end
    o_code = 7'b0001000;
    @(negedge clk);
    checks++;
    if ({o_val, o_ill, o_seq, o_cnt, o_lck} !== {3'd4, 1'b0, 1'b1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL onehot_seq_err: val/ill/seq/cnt/lck=%0d/%b/%b/%0d/%b want 4/0/1/1/0", o_val, o_ill, o_seq, o_cnt, o_lck);
    end
    // Reseeded in TRACK at 4: three in-sequence codes relock.
    for (int i = 0; i < 3; i++) begin
      o_code = rel[i];
      @(negedge clk);
      checks++;
      if ({o_seq, o_lck} !== {1'b0, (i == 2)}) begin
        errors++;
        $display("FAIL onehot_relock[%0d]: seq/lck=%b/%b want 0/%b", i, o_seq, o_lck, (i == 2));
      end
    end
    o_vld = 1'b0;
  endtask

  task automatic test_onehot_illegal_clr;
    o_vld = 1'b1; o_code = 7'b0000011;
    @(negedge clk);
    checks++;
    if ({o_ill, o_seq, o_val, o_cnt, o_lck} !== {1'b1, 1'b0, 3'd0, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL onehot_illegal: ill/seq/val/cnt/lck=%b/%b/%0d/%0d/%b want 1/0/0/2/0", o_ill, o_seq, o_val, o_cnt, o_lck);
    end
    o_code = 7'b0000101; o_clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_ill, o_cnt} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL onehot_clr_priority: ill/cnt=%b/%0d want 1/0", o_ill, o_cnt);
    end
    o_vld = 1'b0; o_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_ovld, o_ill, o_cnt} !== {2'b00, 8'd0}) begin
      errors++;
      $display("FAIL onehot_after_clr: vld/ill/cnt=%b/%b/%0d want 0/0/0", o_ovld, o_ill, o_cnt);
    end
  endtask

  task automatic test_saturation;
    g_vld = 1'b1; g_code = 7'b1000000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 9) begin
        checks++;
        if (g_cnt !== 8'd11) begin
          errors++;
          $display("FAIL sat_count_mid: got %0d want 11", g_cnt);
        end
      end
    end
    g_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (g_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_count_hold: got %0d want 255", g_cnt);
    end
    g_clr = 1'b1;
    @(negedge clk);
    g_clr = 1'b0;
    checks++;
    if (g_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_clear: got %0d want 0", g_cnt);
    end
  endtask

  task automatic test_gaps;
    // Gray 0,1,2,3 with idle cycles interleaved; valid=0 entries are gaps.
    logic [6:0] codes [8] = '{7'b0000000, 7'b0, 7'b0000001, 7'b0, 7'b0, 7'b0000011, 7'b0, 7'b0000010};
    logic       vlds  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] vals  [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 8; i++) begin
      g_vld = vlds[i]; g_code = codes[i];
      @(negedge clk);
      checks++;
      if ({g_ovld, g_val, g_lck} !== {vlds[i], vals[i], (i == 7)}) begin
        errors++;
        $display("FAIL gaps[%0d]: vld/val/lck=%b/%0d/%b want %b/%0d/%b", i, g_ovld, g_val, g_lck, vlds[i], vals[i], (i == 7));
      end
    end
    g_vld = 1'b0;
  endtask

  task automatic test_reset_midstream;
    logic [6:0] codes [4] = '{7'b0000110, 7'b0000111, 7'b0000101, 7'b0000100};
    g_vld = 1'b1; g_code = 7'b0000110;
    #2;
    rst_n = 1'b0; g_vld = 1'b0;
    #1;
    checks++;
    if ({g_ovld, g_val, g_ill, g_seq, g_lck, g_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL midreset_async: got %b want all zero", {g_ovld, g_val, g_ill, g_seq, g_lck, g_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g_vld = 1'b1; g_code = codes[i];
      @(negedge clk);
      checks++;
      if ({g_val, g_lck} !== {3'(i + 4), (i == 3)}) begin
        errors++;
        $display("FAIL midreset_relock[%0d]: val/lck=%0d/%b want %0d/%b", i, g_val, g_lck, i + 4, (i == 3));
      end
    end
    g_vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_gray_lock();
    test_gray_illegal();
    test_onehot_seq();
    test_onehot_illegal_clr();
    test_saturation();
    test_gaps();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
